rr_mux2_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 2-bit channel fed by N requesters. It chooses one requester at a time and holds that grant for a multi-beat packet until the requester's Last beat is accepted. It drives the select of a Mux2_N1 instance, which steers that requester's 2-bit lane to a single valid/ready output toward the downstream consumer.

---
 rtl/arb_pkg.sv | 39 +++
 rtl/rr_mux2_arbiter_mux2_n1.sv | 26 ++
 rtl/rr_mux2_arbiter.sv | 99 +++++++++
 tb/tb_rr_mux2_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// +--------------------------------------------------------------------+
// | arb_pkg: shared arbiter state encoding and rotating-priority pick  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int ARB_MAX_N = 64;
  localparam int ARB_IDX_W = 6;

  // Returns {found, idx}: first set bit of req[0..n-1] scanning ptr, ptr+1, ... with wrap at n.
  function automatic logic [ARB_IDX_W:0] rr_pick(
    input logic [ARB_MAX_N-1:0] req,
    input logic [ARB_IDX_W-1:0] ptr,
    input logic [ARB_IDX_W:0]   n
  );
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
    logic [ARB_IDX_W:0]   j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < ARB_MAX_N; k++) begin
      j = {1'b0, ptr} + k[ARB_IDX_W:0];
      if (j >= n) j = j - n;
      if (!found && (k[ARB_IDX_W:0] < n) && req[j[ARB_IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = j[ARB_IDX_W-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux2_arbiter_mux2_n1.sv
// +--------------------------------------------------------------------+
// | Mux2_N1: N-to-1 selector of 2-bit lanes, output forced to 0 when   |
// | not enabled. Rev 1.0                                               |
// +--------------------------------------------------------------------+
`default_nettype none

module Mux2_N1 #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [2*N-1:0] Vin,
  input  logic [IW-1:0]  Sel,
  input  logic           En,
  output logic [1:0]     Vout
);

  always_comb begin
    Vout = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (En && (Sel == IW'(i))) Vout = Vin[2*i +: 2];
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_mux2_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_mux2_arbiter: round-robin packet arbiter steering one of N      |
// | 2-bit lanes to a valid/ready output. Rev 1.0                       |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_mux2_arbiter
  import arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [N-1:0]         Req,
  input  logic [N-1:0]         Last,
  input  logic [2*N-1:0]       Din,
  input  logic                 Ready,
  output logic                 Valid,
  output logic [1:0]           Dout,
  output logic [N-1:0]         Gnt,
  output logic [$clog2(N)-1:0] GntIdx
);

  localparam int IW = $clog2(N);

  logic [0:0]           r_state;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_gntidx;
  logic [N-1:0]         r_gnt;

  logic                 w_xfer;
  logic                 w_eop;
  logic [IW-1:0]        w_next_ptr;
  logic [IW-1:0]        w_scan_ptr;
  logic [ARB_MAX_N-1:0] w_req_ext;
  logic [ARB_IDX_W-1:0] w_ptr_ext;
  logic                 w_found;
  logic [IW-1:0]        w_pick_idx;

  assign Valid  = (r_state == ST_BUSY) && Req[r_gntidx];
  assign Gnt    = r_gnt;
  assign GntIdx = r_gntidx;

  assign w_xfer     = Valid && Ready;
  assign w_eop      = w_xfer && Last[r_gntidx];
  assign w_next_ptr = (r_gntidx == IW'(N - 1)) ? '0 : r_gntidx + IW'(1);
  // On end of packet the scan already starts past the finishing requester.
  assign w_scan_ptr = w_eop ? w_next_ptr : r_ptr;
  assign w_found    = |Req;

  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = Req;
    w_ptr_ext        = '0;
    w_ptr_ext[IW-1:0] = w_scan_ptr;
    w_pick_idx       = IW'(rr_pick(w_req_ext, w_ptr_ext, (ARB_IDX_W + 1)'(N)));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_gntidx <= '0;
      r_gnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state  <= ST_BUSY;
            r_gntidx <= w_pick_idx;
            r_gnt    <= {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
          end
        end
        default: begin
          if (w_eop) begin
            r_ptr <= w_next_ptr;
            if (w_found) begin
              r_gntidx <= w_pick_idx;
              r_gnt    <= {{(N-1){1'b0}}, 1'b1} << w_pick_idx;
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
            end
          end
        end
      endcase
    end
  end

  Mux2_N1 #(.N(N), .IW(IW)) u_mux (
    .Vin  (Din),
    .Sel  (r_gntidx),
    .En   (Valid),
    .Vout (Dout)
  );

endmodule

`default_nettype wire

// File: tb/tb_rr_mux2_arbiter.sv
// Randomized and directed check of rr_mux2_arbiter against a cycle-level model,
// plus a short N=3 wrap check on a second instance.
`default_nettype none

module tb_rr_mux2_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req, last;
  logic [2*N-1:0] din;
  logic           ready;
  logic           valid;
  logic [1:0]     dout;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  gntidx;

  rr_mux2_arbiter #(.N(N)) dut (
    .Clk(clk), .Rst(rst), .Req(req), .Last(last), .Din(din), .Ready(ready),
    .Valid(valid), .Dout(dout), .Gnt(gnt), .GntIdx(gntidx)
  );

  logic       rst3;
  logic [2:0] req3, last3;
  logic [5:0] din3;
  logic       ready3, valid3;
  logic [1:0] dout3;
  logic [2:0] gnt3;
  logic [1:0] gntidx3;

  rr_mux2_arbiter #(.N(3)) dut3 (
    .Clk(clk), .Rst(rst3), .Req(req3), .Last(last3), .Din(din3), .Ready(ready3),
    .Valid(valid3), .Dout(dout3), .Gnt(gnt3), .GntIdx(gntidx3)
  );

  typedef struct packed {
    logic          v;
    logic [1:0]    d;
    logic [N-1:0]  g;
    logic [IW-1:0] i;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: owner of the channel, whether it is held, and the rotating start point.
  bit m_busy = 0;
  int m_own  = 0;
  int m_ptr  = 0;

  function automatic void m_arbitrate(input logic [N-1:0] rq);
    bit hit = 0;
    for (int k = 0; k < N; k++) begin
      int j = (m_ptr + k) % N;
      if (!hit && rq[j]) begin
        hit = 1; m_own = j;
      end
    end
    m_busy = hit;
  endfunction

  // Drive one cycle (called just after a rising edge); r gives a reset pulse released mid-cycle.
  task automatic cycle(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lt,
                       input logic [2*N-1:0] d, input logic rd);
    exp_t e;
    logic [N-1:0] one = 1;
    rst = r; req = rq; last = lt; din = d; ready = rd;
    if (r) begin
      m_busy = 0; m_own = 0; m_ptr = 0;
      e = '0;
      sb.push_back(e);
      m_arbitrate(rq);
      @(negedge clk); #1 rst = 1'b0;
    end else begin
      e.v = m_busy && rq[m_own];
      e.d = e.v ? d[2*m_own +: 2] : 2'b00;
      e.g = m_busy ? (one << m_own) : '0;
      e.i = IW'(m_own);
      sb.push_back(e);
      if (!m_busy) m_arbitrate(rq);
      else if (e.v && rd && lt[m_own]) begin
        m_ptr = (m_own + 1) % N;
        m_arbitrate(rq);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (valid !== e.v || dout !== e.d || gnt !== e.g || gntidx !== e.i) begin
        failures++;
        $display("FAIL out cyc%0d got v=%b d=%b g=%b i=%0d want v=%b d=%b g=%b i=%0d",
                 cyc, valid, dout, gnt, gntidx, e.v, e.d, e.g, e.i);
      end
    end
  end

  function automatic logic [N-1:0] rbits(input int pct);
    logic [N-1:0] b;
    for (int k = 0; k < N; k++) b[k] = ($urandom_range(0, 99) < pct);
    return b;
  endfunction

  initial begin
    rst = 1'b1; req = '0; last = '0; din = '0; ready = 1'b0;
    rst3 = 1'b1; req3 = 3'b111; last3 = 3'b111; din3 = 6'b10_01_11; ready3 = 1'b1;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || dout !== 2'b00 || gnt !== '0 || gntidx !== '0 ||
        valid3 !== 1'b0 || gnt3 !== 3'b000) begin
      failures++;
      $display("FAIL reset_state got v=%b d=%b g=%b i=%0d v3=%b g3=%b want all zero",
               valid, dout, gnt, gntidx, valid3, gnt3);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Fairness: everyone requesting single-beat packets.
    for (int k = 0; k < 9; k++) cycle(0, 4'b1111, 4'b1111, 8'($urandom), 1);

    // Multi-beat hold on requester 0.
    cycle(1, 4'b0011, 4'b0000, 8'($urandom), 1);
    cycle(0, 4'b0011, 4'b0000, 8'b0000_0001, 1);
    cycle(0, 4'b0011, 4'b0000, 8'b0000_0010, 1);
    cycle(0, 4'b0011, 4'b0001, 8'b0000_0011, 1);
    cycle(0, 4'b0011, 4'b0000, 8'($urandom), 1);

    // Reset in the middle of requester 2's packet.
    cycle(1, 4'b0100, 4'b0000, 8'($urandom), 1);
    cycle(0, 4'b0100, 4'b0000, 8'($urandom), 1);
    cycle(1, 4'b0100, 4'b0000, 8'($urandom), 1);
    cycle(0, 4'b0100, 4'b0100, 8'($urandom), 1);

    // Backpressure then a request gap on requester 1.
    cycle(1, 4'b0010, 4'b0000, 8'b0000_1000, 0);
    cycle(0, 4'b0010, 4'b0010, 8'b0000_1000, 0);
    cycle(0, 4'b0010, 4'b0010, 8'b0000_1000, 0);
    cycle(0, 4'b0000, 4'b0010, 8'b0000_1000, 1);
    cycle(0, 4'b0110, 4'b0010, 8'b0000_1000, 1);
    cycle(0, 4'b0110, 4'b0000, 8'($urandom), 1);

    // Single requester streaming one-beat packets.
    cycle(1, 4'b1000, 4'b1000, 8'($urandom), 1);
    for (int k = 0; k < 5; k++) cycle(0, 4'b1000, 4'b1000, 8'($urandom), 1);

    // Random traffic with occasional resets.
    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(0, 149) == 0, rbits(70), rbits(35), 8'($urandom),
            $urandom_range(0, 99) < 70);

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d left want 0", sb.size());
    end

    // N=3: wrap from index 2 back to 0, one grant per cycle.
    @(posedge clk); #1 rst3 = 1'b0;
    for (int k = 0; k < 7; k++) begin
      int w;
      logic [2:0] one3;
      @(posedge clk); @(negedge clk);
      w = k % 3;
      one3 = 3'b001 << w;
      checks++;
      if (gntidx3 !== 2'(w) || gnt3 !== one3 || valid3 !== 1'b1 || dout3 !== din3[2*w +: 2]) begin
        failures++;
        $display("FAIL n3_wrap step%0d got i=%0d g=%b v=%b d=%b want i=%0d g=%b v=1 d=%b",
                 k, gntidx3, gnt3, valid3, dout3, w, one3, din3[2*w +: 2]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
